// File: rtl/relprime_engine_if.sv
// Handshake/result bundle for relprime_engine; the cycles field exists only
// when RELPRIME_CYCLE_COUNT_EN is defined.
interface relprime_engine_if #(
    parameter int unsigned WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] n;
    logic [WIDTH-1:0] out;
    logic             busy;
    logic             done;
    logic             err;
`ifdef RELPRIME_CYCLE_COUNT_EN
    logic [31:0]      cycles;

    modport master (output start, n, input out, busy, done, err, cycles);
    modport slave  (input start, n, output out, busy, done, err, cycles);
`else
    modport master (output start, n, input out, busy, done, err);
    modport slave  (input start, n, output out, busy, done, err);
`endif
endinterface

// File: rtl/relprime_engine.sv
// Finds the smallest m >= 2 coprime to n using a subtract/swap GCD per candidate.
// Optional feature macro: RELPRIME_CYCLE_COUNT_EN adds the 32-bit cycles output.
module relprime_engine #(
    parameter int unsigned WIDTH = 16
) (
    input  logic            CLK,
    input  logic            reset_n,
    relprime_engine_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        GCD,
        CHECK,
        FIN
    } state_t;

    localparam logic [WIDTH-1:0] M_FIRST = WIDTH'(2);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] n_q, n_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             err_q, err_d;
    logic             accept;
    logic             busy;

    assign busy   = (state_q == LOAD) || (state_q == GCD) || (state_q == CHECK);
    assign accept = bus.start && ((state_q == IDLE) || (state_q == FIN));

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        m_d     = m_q;
        a_d     = a_q;
        b_d     = b_q;
        out_d   = out_q;
        err_d   = err_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    n_d     = bus.n;
                    m_d     = M_FIRST;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                a_d     = n_q;
                b_d     = m_q;
                state_d = GCD;
            end
            GCD: begin
                if (b_q == '0) begin
                    state_d = CHECK;
                end else if (a_q >= b_q) begin
                    a_d = a_q - b_q;
                end else begin
                    a_d = b_q;
                    b_d = a_q;
                end
            end
            CHECK: begin
                // a now holds gcd(n_q, m_q)
                if (a_q == ONE) begin
                    out_d   = m_q;
                    err_d   = 1'b0;
                    state_d = FIN;
                end else if (m_q == '1) begin
                    out_d   = '0;
                    err_d   = 1'b1;
                    state_d = FIN;
                end else begin
                    m_d     = m_q + ONE;
                    state_d = LOAD;
                end
            end
            FIN: begin
                if (accept) begin
                    n_d     = bus.n;
                    m_d     = M_FIRST;
                    state_d = LOAD;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            n_q     <= '0;
            m_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            out_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            m_q     <= m_d;
            a_q     <= a_d;
            b_q     <= b_d;
            out_q   <= out_d;
            err_q   <= err_d;
        end
    end

    assign bus.out  = out_q;
    assign bus.err  = err_q;
    assign bus.busy = busy;
    assign bus.done = (state_q == FIN);

`ifdef RELPRIME_CYCLE_COUNT_EN
    logic [31:0] cyc_q, cyc_d;

    // Counts every edge after the accept edge while busy, so the edge entering FIN is included.
    always_comb begin
        cyc_d = cyc_q;
        if (accept) begin
            cyc_d = '0;
        end else if (busy && (cyc_q != '1)) begin
            cyc_d = cyc_q + 32'd1;
        end
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            cyc_q <= '0;
        end else begin
            cyc_q <= cyc_d;
        end
    end

    assign bus.cycles = cyc_q;
`endif

endmodule

// File: tb/tb_relprime_engine.sv
// Directed-vector bench for relprime_engine at WIDTH 16 and WIDTH 4.
module tb_relprime_engine;

    localparam int unsigned BUDGET = 40000;

    logic CLK;
    logic reset_n;

    relprime_engine_if #(.WIDTH(16)) bus16 ();
    relprime_engine_if #(.WIDTH(4))  bus4  ();

    relprime_engine #(.WIDTH(16)) dut16 (.CLK(CLK), .reset_n(reset_n), .bus(bus16));
    relprime_engine #(.WIDTH(4))  dut4  (.CLK(CLK), .reset_n(reset_n), .bus(bus4));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [15:0] n;
        logic [15:0] exp_out;
        logic        exp_err;
    } vec_t;

    vec_t v16[8];
    vec_t v4[4];

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic launch16(input logic [15:0] nv);
        @(negedge CLK);
        bus16.n     = nv;
        bus16.start = 1'b1;
        @(posedge CLK);
        #1 bus16.start = 1'b0;
    endtask

    task automatic wait16(output int lat, output bit ok);
        lat = 0;
        ok  = 1'b0;
        while (lat < BUDGET) begin
            @(posedge CLK);
            #1;
            lat++;
            if (bus16.done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic launch4(input logic [3:0] nv);
        @(negedge CLK);
        bus4.n     = nv;
        bus4.start = 1'b1;
        @(posedge CLK);
        #1 bus4.start = 1'b0;
    endtask

    task automatic wait4(output int lat, output bit ok);
        lat = 0;
        ok  = 1'b0;
        while (lat < BUDGET) begin
            @(posedge CLK);
            #1;
            lat++;
            if (bus4.done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        int  lat;
        bit  ok;
        bit  seen;
        string nm;

        v16[0] = '{16'd21748, 16'd3,  1'b0};
        v16[1] = '{16'd30,    16'd7,  1'b0};
        v16[2] = '{16'd65535, 16'd2,  1'b0};
        v16[3] = '{16'd1,     16'd2,  1'b0};
        v16[4] = '{16'd2,     16'd3,  1'b0};
        v16[5] = '{16'd210,   16'd11, 1'b0};
        v16[6] = '{16'd12,    16'd5,  1'b0};
        v16[7] = '{16'd7,     16'd2,  1'b0};

        v4[0] = '{16'd0,  16'd0, 1'b1};
        v4[1] = '{16'd15, 16'd2, 1'b0};
        v4[2] = '{16'd12, 16'd5, 1'b0};
        v4[3] = '{16'd14, 16'd3, 1'b0};

        reset_n     = 1'b0;
        bus16.start = 1'b0;
        bus16.n     = '0;
        bus4.start  = 1'b0;
        bus4.n      = '0;

        repeat (2) @(posedge CLK);
        #1;
        check("rst_out",  bus16.out,  0);
        check("rst_err",  bus16.err,  0);
        check("rst_busy", bus16.busy, 0);
        check("rst_done", bus16.done, 0);
        check("rst4_out", bus4.out,   0);
`ifdef RELPRIME_CYCLE_COUNT_EN
        check("rst_cycles", bus16.cycles, 0);
`endif
        @(negedge CLK);
        reset_n = 1'b1;

        // WIDTH 16 directed vectors
        for (int i = 0; i < 8; i++) begin
            launch16(v16[i].n);
            check($sformatf("busy_after_accept_n%0d", v16[i].n), bus16.busy, 1);
            wait16(lat, ok);
            check($sformatf("done_seen_n%0d", v16[i].n), ok, 1);
            check($sformatf("out_n%0d", v16[i].n), bus16.out, v16[i].exp_out);
            check($sformatf("err_n%0d", v16[i].n), bus16.err, v16[i].exp_err);
            check($sformatf("busy_at_done_n%0d", v16[i].n), bus16.busy, 0);
            if (v16[i].n == 16'd1) begin
                check("latency_n1", lat, 7);
`ifdef RELPRIME_CYCLE_COUNT_EN
                check("cycles_n1", bus16.cycles, lat);
`endif
            end
            @(posedge CLK);
            #1;
            check($sformatf("done_one_cycle_n%0d", v16[i].n), bus16.done, 0);
            check($sformatf("out_held_n%0d", v16[i].n), bus16.out, v16[i].exp_out);
        end

        // WIDTH 4 directed vectors, including the n = 0 error sweep
        for (int i = 0; i < 4; i++) begin
            launch4(v4[i].n[3:0]);
            wait4(lat, ok);
            check($sformatf("w4_done_seen_n%0d", v4[i].n), ok, 1);
            check($sformatf("w4_out_n%0d", v4[i].n), bus4.out, v4[i].exp_out);
            check($sformatf("w4_err_n%0d", v4[i].n), bus4.err, v4[i].exp_err);
            repeat (3) @(posedge CLK);
            #1;
            check($sformatf("w4_done_low_n%0d", v4[i].n), bus4.done, 0);
            check($sformatf("w4_err_held_n%0d", v4[i].n), bus4.err, v4[i].exp_err);
            check($sformatf("w4_out_held_n%0d", v4[i].n), bus4.out, v4[i].exp_out);
        end

        // start re-pulsed while busy must be ignored
        launch16(16'd5040);
        repeat (20) @(posedge CLK);
        @(negedge CLK);
        bus16.n     = 16'd30;
        bus16.start = 1'b1;
        @(negedge CLK);
        bus16.start = 1'b0;
        check("repulse_busy", bus16.busy, 1);
        wait16(lat, ok);
        check("repulse_done_seen", ok, 1);
        check("repulse_out", bus16.out, 11);
        check("repulse_err", bus16.err, 0);
        repeat (5) @(posedge CLK);
        #1;
        check("repulse_no_second_run", bus16.busy, 0);

        // reset mid-GCD abandons the run; next accept happens on first edge
        launch16(16'd65535);
        repeat (10) @(posedge CLK);
        @(negedge CLK);
        reset_n = 1'b0;
        #1;
        check("abort_busy", bus16.busy, 0);
        check("abort_done", bus16.done, 0);
        check("abort_out",  bus16.out,  0);
        check("abort_err",  bus16.err,  0);
        @(negedge CLK);
        reset_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(posedge CLK);
            #1;
            if (bus16.done) seen = 1'b1;
        end
        check("abort_no_done", seen, 0);
        @(negedge CLK);
        reset_n = 1'b0;
        @(negedge CLK);
        reset_n     = 1'b1;
        bus16.n     = 16'd21784;
        bus16.start = 1'b1;
        @(posedge CLK);
        #1 bus16.start = 1'b0;
        check("first_edge_accept", bus16.busy, 1);
        wait16(lat, ok);
        check("post_reset_done_seen", ok, 1);
        check("post_reset_out", bus16.out, 3);
        check("post_reset_err", bus16.err, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/relprime_engine.md
RELPRIME_ENGINE -- requirements
Module: relprime_engine

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the operand and result width in bits (legal range 4..32).
REQ-002 The block SHALL have port CLK, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port reset_n, input, 1 bit: the reset, which is asynchronous and active-low.
REQ-004 The block SHALL have port start, input, 1 bit: a request that launches a computation on n.
REQ-005 The block SHALL have port n, input, WIDTH bits: the operand, sampled only on the cycle start is accepted.
REQ-006 The block SHALL have port out, output, WIDTH bits: the smallest m >= 2 with gcd(n,m) = 1.
REQ-007 The block SHALL have port busy, output, 1 bit: high while a computation is in progress.
REQ-008 The block SHALL have port done, output, 1 bit: a one-cycle completion pulse.
REQ-009 The block SHALL have port err, output, 1 bit: high when no coprime m exists within WIDTH bits; valid while done is high and held until the next accept.

Function
REQ-010 The block SHALL implement the states IDLE, LOAD, GCD, CHECK and FIN.
REQ-011 The block SHALL accept start only in IDLE or FIN, capturing n into n_q, setting m to 2 and entering LOAD on the next edge.
REQ-012 The block SHALL ignore start while busy is high, with no effect on any state or output.
REQ-013 In LOAD, the block SHALL set a <= n_q and b <= m, then enter GCD.
REQ-014 In GCD, each cycle the block SHALL do exactly one of the following, in priority order:
- if b == 0, enter CHECK;
- else if a >= b, set a <= a - b;
- else swap a and b.
REQ-015 In CHECK, the block SHALL act on a, which holds gcd(n_q, m), as follows:
- if a == 1: out <= m, err <= 0, enter FIN;
- else if m == 2^WIDTH - 1: out <= 0, err <= 1, enter FIN;
- otherwise: m <= m + 1, enter LOAD.
REQ-016 In FIN, the block SHALL assert done for exactly one cycle and then return to IDLE, unless start is accepted in that same cycle, in which case it SHALL go to LOAD.
REQ-017 The block SHALL hold busy high in LOAD, GCD and CHECK, and low in IDLE and FIN.
REQ-018 The block SHALL hold out and err stable from FIN until the next result is written.
REQ-019 The block SHALL use unsigned WIDTH-bit arithmetic throughout; the subtraction in GCD never underflows because it is guarded by a >= b.
REQ-020 For n = 0, the block SHALL report err = 1, since gcd(0,m) = m; it SHALL NOT hang.
REQ-021 For n = 1, the block SHALL report out = 2.
REQ-022 The block SHALL have a latency from accept to done of at most 2^WIDTH * (2^WIDTH + 3) cycles; there is no fixed latency, and the bench uses done.

Reset
REQ-023 Asserting reset_n low SHALL immediately force the state to IDLE and set out = 0, err = 0, busy = 0, done = 0, and n_q, m, a and b to 0.
REQ-024 Reset asserted mid-computation SHALL abandon the computation with no done pulse.
REQ-025 After reset deasserts, the block SHALL accept start on the first rising edge of CLK.

Configuration
REQ-026 When the macro RELPRIME_CYCLE_COUNT_EN is defined, the block SHALL add output cycles, 32 bits, which counts the edges from accept to FIN inclusive.
REQ-027 The cycles output SHALL be cleared on accept and by reset, saturate at 2^32 - 1, and be held until the next accept.
REQ-028 When RELPRIME_CYCLE_COUNT_EN is undefined, the cycles port and its counter SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-029 Scenario: WIDTH = 16, n = 21748, start pulsed for one cycle -> single done pulse, out = 3, err = 0.
REQ-030 Scenario: n = 5040 -> out = 11; n = 30 -> out = 7; n = 65535 -> out = 2; n = 1 -> out = 2.
REQ-031 Scenario: n = 0 with WIDTH = 4 -> done with err = 1 and out = 0 after m sweeps 2..15.
REQ-032 Scenario: start re-pulsed with n = 30 while busy during an n = 5040 computation -> ignored; out = 11.
REQ-033 Scenario: reset_n pulsed low mid-GCD, then start with n = 21784 -> no done from the aborted run; then out = 3.
REQ-034 Scenario: with RELPRIME_CYCLE_COUNT_EN defined, n = 1 -> cycles equals the cycle count measured by the bench from accept to done.
